// File: rtl/led_mode_sequencer_pkg.sv
// Shared encodings for the LED mode sequencer: mode values, colour indices and duty width.
package led_pkg;

   localparam int DUTY_W = 8;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_CYCLE   = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_SOLID   = 2'd3
   } mode_t;

   localparam logic [1:0] COL_BLUE  = 2'd0;
   localparam logic [1:0] COL_GREEN = 2'd1;
   localparam logic [1:0] COL_RED   = 2'd2;
   localparam logic [1:0] COL_BLACK = 2'd3;

   // Packs one colour index into an {r,g,b} duty word at the given brightness.
   function automatic logic [3*DUTY_W-1:0] colour_duty(input logic [1:0]        col,
                                                       input logic [DUTY_W-1:0] bright);
      logic [3*DUTY_W-1:0] d;
      d = '0;
      case (col)
         COL_BLUE:  d = {{(2*DUTY_W){1'b0}}, bright};
         COL_GREEN: d = {{DUTY_W{1'b0}}, bright, {DUTY_W{1'b0}}};
         COL_RED:   d = {bright, {(2*DUTY_W){1'b0}}};
         default:   d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/led_mode_sequencer_if.sv
// Button-in / duty-out bundle between the debouncer side and the sequencer.
interface led_mode_sequencer_if import led_pkg::*; ();

   logic [1:0]          btn_db;
   logic [3*DUTY_W-1:0] led4_duty;
   logic [3*DUTY_W-1:0] led5_duty;
   logic [1:0]          mode;
   logic                paused;

   modport master (
      output btn_db,
      input  led4_duty,
      input  led5_duty,
      input  mode,
      input  paused
   );

   modport slave (
      input  btn_db,
      output led4_duty,
      output led5_duty,
      output mode,
      output paused
   );

endinterface

// File: rtl/led_mode_sequencer_tick_gen.sv
// Free-running divider: counts 0..DIV-1 while enabled and pulses tick on the last count.
module tick_gen #(
   parameter int DIV = 2
) (
   input  logic sysclk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/led_mode_sequencer.sv
// Mode/pause sequencer producing six 8-bit PWM duties for LED4 and LED5.
// Define LED_GAMMA_EN for a squared (perceptual) breathe curve; linear otherwise.
//
// state        | meaning
// MODE_OFF     | all duties 0
// MODE_CYCLE   | LED4 shows colour c, LED5 colour c+1, c steps on step_tick
// MODE_BREATHE | LED4 green ramps up/down, LED5 blue mirrors it
// MODE_SOLID   | all duties at BRIGHT
module led_mode_sequencer import led_pkg::*; #(
   parameter int CLK_HZ  = 125000000,
   parameter int STEP_HZ = 2,
   parameter int RAMP_HZ = 500,
   parameter int BRIGHT  = 127
) (
   input  logic                 sysclk,
   input  logic                 rst,
   led_mode_sequencer_if.slave  bus
);

   localparam int STEP_DIV = CLK_HZ / STEP_HZ;
   localparam int RAMP_DIV = CLK_HZ / RAMP_HZ;
   localparam logic [DUTY_W-1:0] BRIGHT_D = DUTY_W'(BRIGHT);

   logic [1:0]          btn_s, btn_d, rise;
   logic                adv, tog;
   mode_t               state_q, state_d;
   logic                paused_q;
   logic [1:0]          colour_q;
   logic [DUTY_W-1:0]   level_q;
   logic                dir_down_q;
   logic                step_tick, ramp_tick;
   logic [3*DUTY_W-1:0] led4_d, led5_d, led4_q, led5_q;

   // One register stage, then edge detect against it: a press acts two cycles after btn_db.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         btn_s <= '0;
         btn_d <= '0;
      end else begin
         btn_s <= bus.btn_db;
         btn_d <= btn_s;
      end
   end

   assign rise = btn_s & ~btn_d;
   assign adv  = rise[0];
   assign tog  = rise[1] & ~rise[0];

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) state_q <= MODE_OFF;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (adv) begin
         unique case (state_q)
            MODE_OFF:     state_d = MODE_CYCLE;
            MODE_CYCLE:   state_d = MODE_BREATHE;
            MODE_BREATHE: state_d = MODE_SOLID;
            MODE_SOLID:   state_d = MODE_OFF;
            default:      state_d = MODE_OFF;
         endcase
      end
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst)       paused_q <= 1'b0;
      else if (adv)  paused_q <= 1'b0;
      else if (tog)  paused_q <= ~paused_q;
   end

   tick_gen #(.DIV(STEP_DIV)) u_step (
      .sysclk (sysclk),
      .rst    (rst),
      .en     ((state_q == MODE_CYCLE) && !paused_q),
      .clr    (adv),
      .tick   (step_tick)
   );

   tick_gen #(.DIV(RAMP_DIV)) u_ramp (
      .sysclk (sysclk),
      .rst    (rst),
      .en     ((state_q == MODE_BREATHE) && !paused_q),
      .clr    (adv),
      .tick   (ramp_tick)
   );

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst)            colour_q <= COL_BLUE;
      else if (adv)       colour_q <= COL_BLUE;
      else if (step_tick) colour_q <= colour_q + 2'd1;
   end

   // Triangle ramp: the turn-around is decided in the same update that lands on 255 or 0.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         level_q    <= '0;
         dir_down_q <= 1'b0;
      end else if (adv) begin
         level_q    <= '0;
         dir_down_q <= 1'b0;
      end else if (ramp_tick) begin
         if (!dir_down_q) begin
            level_q <= level_q + 1'b1;
            if (level_q == 8'd254) dir_down_q <= 1'b1;
         end else begin
            level_q <= level_q - 1'b1;
            if (level_q == 8'd1) dir_down_q <= 1'b0;
         end
      end
   end

`ifdef LED_GAMMA_EN
   function automatic logic [DUTY_W-1:0] shape(input logic [DUTY_W-1:0] x);
      logic [2*DUTY_W-1:0] sq;
      sq = {{DUTY_W{1'b0}}, x} * {{DUTY_W{1'b0}}, x};
      return sq[2*DUTY_W-1:DUTY_W];
   endfunction
`else
   function automatic logic [DUTY_W-1:0] shape(input logic [DUTY_W-1:0] x);
      return x;
   endfunction
`endif

   always_comb begin
      led4_d = '0;
      led5_d = '0;
      unique case (state_q)
         MODE_CYCLE: begin
            led4_d = colour_duty(colour_q, BRIGHT_D);
            led5_d = colour_duty(colour_q + 2'd1, BRIGHT_D);
         end
         MODE_BREATHE: begin
            led4_d = {{DUTY_W{1'b0}}, shape(level_q), {DUTY_W{1'b0}}};
            led5_d = {{(2*DUTY_W){1'b0}}, shape(~level_q)};
         end
         MODE_SOLID: begin
            led4_d = {3{BRIGHT_D}};
            led5_d = {3{BRIGHT_D}};
         end
         default: begin
            led4_d = '0;
            led5_d = '0;
         end
      endcase
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         led4_q <= '0;
         led5_q <= '0;
      end else begin
         led4_q <= led4_d;
         led5_q <= led5_d;
      end
   end

   assign bus.led4_duty = led4_q;
   assign bus.led5_duty = led5_q;
   assign bus.mode      = state_q;
   assign bus.paused    = paused_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with CLK_HZ=100, STEP_HZ=10, RAMP_HZ=50.
module tb_led_mode_sequencer;

   logic sysclk;
   logic rst;
   int   checks;
   int   failures;

   led_mode_sequencer_if bus ();

   led_mode_sequencer #(
      .CLK_HZ  (100),
      .STEP_HZ (10),
      .RAMP_HZ (50),
      .BRIGHT  (127)
   ) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .bus    (bus)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   typedef struct {
      logic [1:0]  btn;
      int          n;
      logic [1:0]  mode;
      logic        paused;
      logic [23:0] l4;
      logic [23:0] l5;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [7:0] fx(input int x);
      int s;
      s = x;
`ifdef LED_GAMMA_EN
      s = (x * x) >> 8;
`endif
      return 8'(s);
   endfunction

   function automatic logic [23:0] br4(input int l);
      return {8'h00, fx(l), 8'h00};
   endfunction

   function automatic logic [23:0] br5(input int l);
      return {16'h0000, fx(255 - l)};
   endfunction

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [1:0] m, input logic p,
                          input logic [23:0] l4, input logic [23:0] l5);
      chk({name, ".mode"},   {22'd0, bus.mode},   {22'd0, m});
      chk({name, ".paused"}, {23'd0, bus.paused}, {23'd0, p});
      chk({name, ".led4"},   bus.led4_duty,       l4);
      chk({name, ".led5"},   bus.led5_duty,       l5);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic press0();
      bus.btn_db = 2'b01;
      cycles(1);
      bus.btn_db = 2'b00;
      cycles(3);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst        = 1'b1;
      bus.btn_db = 2'b00;

      // Edge E0 is the edge just before reset release; n counts edges from there.
      vecs.push_back('{2'b01,    1, 2'd0, 1'b0, 24'h000000, 24'h000000, "press_lat1"});
      vecs.push_back('{2'b01,    1, 2'd1, 1'b0, 24'h000000, 24'h000000, "duty_lat"});
      vecs.push_back('{2'b01,    1, 2'd1, 1'b0, 24'h00007F, 24'h007F00, "cyc_c0"});
      vecs.push_back('{2'b00,    9, 2'd1, 1'b0, 24'h00007F, 24'h007F00, "cyc_c0_end"});
      vecs.push_back('{2'b00,    1, 2'd1, 1'b0, 24'h007F00, 24'h7F0000, "cyc_c1"});
      vecs.push_back('{2'b00,   10, 2'd1, 1'b0, 24'h7F0000, 24'h000000, "cyc_c2"});
      vecs.push_back('{2'b00,   10, 2'd1, 1'b0, 24'h000000, 24'h00007F, "cyc_c3"});
      vecs.push_back('{2'b00,   10, 2'd1, 1'b0, 24'h00007F, 24'h007F00, "cyc_wrap"});
      vecs.push_back('{2'b10,    2, 2'd1, 1'b1, 24'h00007F, 24'h007F00, "cyc_pause"});
      vecs.push_back('{2'b00,   20, 2'd1, 1'b1, 24'h00007F, 24'h007F00, "cyc_frozen"});
      vecs.push_back('{2'b11,    2, 2'd2, 1'b0, 24'h00007F, 24'h007F00, "both_rise"});
      vecs.push_back('{2'b00,    1, 2'd2, 1'b0, br4(0),     br5(0),     "br_l0"});
      vecs.push_back('{2'b00,   78, 2'd2, 1'b0, br4(39),    br5(39),    "br_l39"});
      vecs.push_back('{2'b10,    2, 2'd2, 1'b1, br4(40),    br5(40),    "br_pause"});
      vecs.push_back('{2'b00,  100, 2'd2, 1'b1, br4(40),    br5(40),    "br_frozen"});
      vecs.push_back('{2'b10,    2, 2'd2, 1'b0, br4(40),    br5(40),    "br_resume"});
      vecs.push_back('{2'b00,    2, 2'd2, 1'b0, br4(41),    br5(41),    "br_l41"});
      vecs.push_back('{2'b00,  174, 2'd2, 1'b0, br4(128),   br5(128),   "br_l128"});
      vecs.push_back('{2'b00,  254, 2'd2, 1'b0, br4(255),   br5(255),   "br_peak"});
      vecs.push_back('{2'b00,    1, 2'd2, 1'b0, br4(255),   br5(255),   "br_peak_hold"});
      vecs.push_back('{2'b00,    1, 2'd2, 1'b0, br4(254),   br5(254),   "br_descend"});
      vecs.push_back('{2'b01, 1000, 2'd3, 1'b0, 24'h7F7F7F, 24'h7F7F7F, "hold_one_adv"});
      vecs.push_back('{2'b00,    5, 2'd3, 1'b0, 24'h7F7F7F, 24'h7F7F7F, "hold_release"});

      repeat (3) @(posedge sysclk);
      #1;
      rst = 1'b0;
      chk_all("reset", 2'd0, 1'b0, 24'h0, 24'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         bus.btn_db = vecs[i].btn;
         cycles(vecs[i].n);
         chk_all(vecs[i].name, vecs[i].mode, vecs[i].paused, vecs[i].l4, vecs[i].l5);
      end

      press0();
      chk_all("solid_to_off", 2'd0, 1'b0, 24'h0, 24'h0);
      for (int k = 1; k <= 4; k++) begin
         press0();
         chk($sformatf("lap_mode%0d", k), {22'd0, bus.mode}, 24'(k % 4));
      end
      chk("lap_led4", bus.led4_duty, 24'h0);
      chk("lap_led5", bus.led5_duty, 24'h0);

      press0();
      press0();
      cycles(50);
      chk("pre_rst_mode", {22'd0, bus.mode}, 24'd2);
      rst = 1'b1;
      #1;
      chk_all("async_rst", 2'd0, 1'b0, 24'h0, 24'h0);
      cycles(2);
      rst = 1'b0;
      cycles(3);
      chk_all("post_rst", 2'd0, 1'b0, 24'h0, 24'h0);
      press0();
      chk_all("post_rst_press", 2'd1, 1'b0, 24'h00007F, 24'h007F00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
